// File: rtl/avalon_slave.sv
// avalon_slave
//   Configuration/status register bank behind an Avalon-MM-style slave port.
//   Every transfer stalls the master with waitrequest for WAIT_CYCLES clocks,
//   then commits the write or loads readdata.
//
//   Optional feature macro: AVALON_SLAVE_ACCESS_CNT_EN
//     defined   -> 0x07 reads a wrapping count of committed R/W register writes
//     undefined -> 0x07 is reserved (reads 8'h00, writes ignored)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   address      register address, sampled in the command cycle
//   Write        single-cycle write command pulse (wins over read)
//   read         single-cycle read command pulse
//   writedata    write data, sampled with Write
//   waitrequest  high while a transfer is in progress
//   readdata     read result, held until the next read completes
module avalon_slave #(
    parameter int         WAIT_CYCLES = 4,
    parameter logic [7:0] VERSION     = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic       Write,
    input  logic       read,
    input  logic [7:0] writedata,
    output logic       waitrequest,
    output logic [7:0] readdata
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic [7:0] lat_addr;
    logic [7:0] lat_data;
    logic       lat_wr;
    // Slots 5 and 7 exist only to keep indexing simple; they are never used.
    logic [7:0] regs [8];
    logic [7:0] rd_val;
    logic       start;
    logic       done;
    logic       wr_hit;
`ifdef AVALON_SLAVE_ACCESS_CNT_EN
    logic [7:0] acc_cnt;
`endif

    assign start       = (state == IDLE) && (read || Write);
    assign done        = (state == BUSY) && (cnt == 8'd0);
    assign waitrequest = (state == BUSY);
    // Only the six R/W registers accept writes.
    assign wr_hit      = (lat_addr <= 8'h06) && (lat_addr != 8'h05);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (read || Write) state_nxt = BUSY;
            BUSY:    if (cnt == 8'd0)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_val = 8'h00;
        case (lat_addr)
            8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06: rd_val = regs[lat_addr[2:0]];
            8'h05:   rd_val = VERSION;
`ifdef AVALON_SLAVE_ACCESS_CNT_EN
            8'h07:   rd_val = acc_cnt;
`endif
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            lat_addr <= 8'h00;
            lat_data <= 8'h00;
            lat_wr   <= 1'b0;
            readdata <= 8'h00;
            // Reset value of register n is {n, n} in nibbles (8'h00, 8'h11, ...).
            for (int i = 0; i < 8; i++) regs[i] <= {4'(i), 4'(i)};
`ifdef AVALON_SLAVE_ACCESS_CNT_EN
            acc_cnt  <= 8'h00;
`endif
        end else begin
            state <= state_nxt;
            if (start) begin
                lat_addr <= address;
                lat_data <= writedata;
                lat_wr   <= Write;
                cnt      <= CNT_LOAD;
            end else if (done) begin
                if (lat_wr) begin
                    if (wr_hit) begin
                        regs[lat_addr[2:0]] <= lat_data;
`ifdef AVALON_SLAVE_ACCESS_CNT_EN
                        acc_cnt <= acc_cnt + 8'd1;
`endif
                    end
                end else begin
                    readdata <= rd_val;
                end
            end else if (state == BUSY) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_slave.sv
module tb_avalon_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic       Write;
    logic       read;
    logic [7:0] writedata;
    logic       waitrequest;
    logic [7:0] readdata;

    int checks = 0;
    int errors = 0;
    int w;
    logic [7:0] exp_tab [7];
    logic [7:0] exp_cnt;

    always #5 clk = ~clk;

    avalon_slave #(.WAIT_CYCLES(4), .VERSION(8'h10)) dut (
        .clk(clk), .reset(reset), .address(address), .Write(Write),
        .read(read), .writedata(writedata), .waitrequest(waitrequest),
        .readdata(readdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer. Inputs change 1 time unit after a rising edge. If poke is
    // set, a stray read to 0x00 is held during the first BUSY cycle.
    // w returns the number of cycles waitrequest was observed high.
    task automatic xfer(input logic wr, input logic rd, input logic [7:0] a,
                        input logic [7:0] d, input bit poke, output int width);
        @(posedge clk); #1;
        Write = wr; read = rd; address = a; writedata = d;
        @(posedge clk); #1;
        Write = 1'b0; read = 1'b0;
        if (poke) begin read = 1'b1; address = 8'h00; end
        width = 0;
        while (waitrequest && width < 100) begin
            width++;
            @(posedge clk); #1;
            read = 1'b0;
        end
        if (width >= 100) check("timeout", 32'(width), 32'd4);
    endtask

    initial begin
        exp_tab = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h10, 8'h66};
        reset = 1'b0; Write = 1'b0; read = 1'b0; address = 8'h00; writedata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wait", 32'(waitrequest), 32'd0);
        check("rst_rdata", 32'(readdata), 32'h00);
        reset = 1'b1;

        // reset values and waitrequest width
        for (int i = 0; i < 7; i++) begin
            xfer(1'b0, 1'b1, 8'(i), 8'h00, 1'b0, w);
            check($sformatf("rst_val_%0d", i), 32'(readdata), 32'(exp_tab[i]));
            check($sformatf("width_%0d", i), 32'(w), 32'd4);
        end

        // write / readback
        xfer(1'b1, 1'b0, 8'h00, 8'd3,   1'b0, w);
        check("wr_width", 32'(w), 32'd4);
        xfer(1'b1, 1'b0, 8'h03, 8'd72,  1'b0, w);
        xfer(1'b1, 1'b0, 8'h04, 8'd23,  1'b0, w);
        xfer(1'b1, 1'b0, 8'h06, 8'd255, 1'b0, w);
        xfer(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, w); check("rb_r0", 32'(readdata), 32'h03);
        xfer(1'b0, 1'b1, 8'h03, 8'h00, 1'b0, w); check("rb_r3", 32'(readdata), 32'h48);
        xfer(1'b0, 1'b1, 8'h04, 8'h00, 1'b0, w); check("rb_r4", 32'(readdata), 32'h17);
        xfer(1'b0, 1'b1, 8'h06, 8'h00, 1'b0, w); check("rb_r6", 32'(readdata), 32'hFF);

        // version is read-only
        xfer(1'b0, 1'b1, 8'h05, 8'h00, 1'b0, w); check("ver_a", 32'(readdata), 32'h10);
        xfer(1'b1, 1'b0, 8'h05, 8'hFF, 1'b0, w);
        xfer(1'b0, 1'b1, 8'h05, 8'h00, 1'b0, w); check("ver_b", 32'(readdata), 32'h10);

        // 0x07: reserved, or write counter (4 committed R/W writes so far)
`ifdef AVALON_SLAVE_ACCESS_CNT_EN
        exp_cnt = 8'h04;
`else
        exp_cnt = 8'h00;
`endif
        xfer(1'b1, 1'b0, 8'h07, 8'd200, 1'b0, w);
        xfer(1'b0, 1'b1, 8'h07, 8'h00, 1'b0, w); check("addr7", 32'(readdata), 32'(exp_cnt));
        xfer(1'b0, 1'b1, 8'h20, 8'h00, 1'b0, w); check("reserved", 32'(readdata), 32'h00);

        // read while busy is ignored
        xfer(1'b0, 1'b1, 8'h03, 8'h00, 1'b1, w);
        check("busy_width", 32'(w), 32'd4);
        check("busy_rdata", 32'(readdata), 32'h48);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("no_pulse_%0d", i), 32'(waitrequest), 32'd0);
            @(posedge clk); #1;
        end
        check("busy_rdata2", 32'(readdata), 32'h48);

        // read+write together: write wins
        xfer(1'b1, 1'b1, 8'h01, 8'h5A, 1'b0, w);
        check("rw_rdata_held", 32'(readdata), 32'h48);
        xfer(1'b0, 1'b1, 8'h01, 8'h00, 1'b0, w); check("rw_r1", 32'(readdata), 32'h5A);
`ifdef AVALON_SLAVE_ACCESS_CNT_EN
        exp_cnt = 8'h05;
`endif
        xfer(1'b0, 1'b1, 8'h07, 8'h00, 1'b0, w); check("addr7_b", 32'(readdata), 32'(exp_cnt));

        // reset two cycles into BUSY discards the write
        @(posedge clk); #1;
        Write = 1'b1; address = 8'h02; writedata = 8'hAB;
        @(posedge clk); #1;
        Write = 1'b0;
        check("mid_busy", 32'(waitrequest), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_wait", 32'(waitrequest), 32'd0);
        check("mid_rst_rdata", 32'(readdata), 32'h00);
        reset = 1'b1;
        xfer(1'b0, 1'b1, 8'h02, 8'h00, 1'b0, w); check("mid_rst_r2", 32'(readdata), 32'h22);
        xfer(1'b0, 1'b1, 8'h01, 8'h00, 1'b0, w); check("mid_rst_r1", 32'(readdata), 32'h11);
        xfer(1'b0, 1'b1, 8'h07, 8'h00, 1'b0, w); check("mid_rst_a7", 32'(readdata), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
